// File: rtl/alu_seq.sv
// Multi-cycle ALU: single-cycle arithmetic/logic ops, iterative shift-left and
// shift-add multiply, with registered result/flags and a start/ready/done handshake.
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry,
  output logic             neg,
  output logic             ovf,
  output logic [1:0]       dbg_state
);
  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_ADC = 3'd5;
  localparam logic [2:0] OP_SHL = 3'd6;
  localparam logic [2:0] OP_MUL = 3'd7;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_SHIFT = 2'd1, S_MULT = 2'd2} state_e;

  // Handshake: a request is taken on any rising edge with start=1 and ready=1;
  // done pulses for exactly the cycle after the edge that wrote result/flags.
  state_e               state_q, state_d;
  logic [2*WIDTH-1:0]   work_q, work_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic                 zero_q, zero_d, carry_q, carry_d;
  logic                 neg_q, neg_d, ovf_q, ovf_d, done_q, done_d;

  logic [WIDTH:0]       sum_w, diff_w;
  logic [CW-1:0]        shamt;
  logic [2*WIDTH-1:0]   mul_next;
  logic [WIDTH-1:0]     shl_next;
  logic                 upd;
  logic [WIDTH-1:0]     res_v;
  logic                 c_v, v_v;

  // ADC folds the held carry into the same adder used by ADD.
  assign sum_w    = {1'b0, A} + {1'b0, B} + {{WIDTH{1'b0}}, (op == OP_ADC) & carry_q};
  assign diff_w   = {1'b0, A} - {1'b0, B};
  assign shamt    = (32'(B) >= 32'(WIDTH)) ? CW'(WIDTH) : CW'(B);
  assign mul_next = work_q + (mplier_q[0] ? mcand_q : '0);
  assign shl_next = work_q[WIDTH-1:0] << 1;

  always_comb begin
    state_d  = state_q;
    work_d   = work_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    zero_d   = zero_q;
    carry_d  = carry_q;
    neg_d    = neg_q;
    ovf_d    = ovf_q;
    done_d   = 1'b0;
    upd      = 1'b0;
    res_v    = '0;
    c_v      = 1'b0;
    v_v      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          case (op)
            OP_ADD, OP_ADC: begin
              upd   = 1'b1;
              res_v = sum_w[WIDTH-1:0];
              c_v   = sum_w[WIDTH];
              v_v   = (A[WIDTH-1] == B[WIDTH-1]) && (sum_w[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SUB: begin
              upd   = 1'b1;
              res_v = diff_w[WIDTH-1:0];
              c_v   = diff_w[WIDTH];
              v_v   = (A[WIDTH-1] != B[WIDTH-1]) && (diff_w[WIDTH-1] != A[WIDTH-1]);
            end
            OP_AND: begin upd = 1'b1; res_v = A & B; end
            OP_OR:  begin upd = 1'b1; res_v = A | B; end
            OP_XOR: begin upd = 1'b1; res_v = A ^ B; end
            OP_SHL: begin
              if (shamt == '0) begin
                upd   = 1'b1;
                res_v = A;
              end else begin
                work_d  = {{WIDTH{1'b0}}, A};
                cnt_d   = shamt;
                state_d = S_SHIFT;
              end
            end
            default: begin
              work_d   = '0;
              mcand_d  = {{WIDTH{1'b0}}, A};
              mplier_d = B;
              cnt_d    = CW'(WIDTH);
              state_d  = S_MULT;
            end
          endcase
        end
      end
      S_SHIFT: begin
        work_d = {{WIDTH{1'b0}}, shl_next};
        cnt_d  = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          upd     = 1'b1;
          res_v   = shl_next;
          c_v     = work_q[WIDTH-1];
          state_d = S_IDLE;
        end
      end
      S_MULT: begin
        work_d   = mul_next;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          upd     = 1'b1;
          res_v   = mul_next[WIDTH-1:0];
          c_v     = |mul_next[2*WIDTH-1:WIDTH];
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (upd) begin
      result_d = res_v;
      carry_d  = c_v;
      ovf_d    = v_v;
      zero_d   = (res_v == '0);
      neg_d    = res_v[WIDTH-1];
      done_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      work_q   <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      carry_q  <= 1'b0;
      neg_q    <= 1'b0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      work_q   <= work_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      carry_q  <= carry_d;
      neg_q    <= neg_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
    end
  end

  assign ready     = (state_q == S_IDLE);
  assign done      = done_q;
  assign result    = result_q;
  assign zero      = zero_q;
  assign carry     = carry_q;
  assign neg       = neg_q;
  assign ovf       = ovf_q;
  assign dbg_state = state_q;
endmodule
